// File: rtl/cpu_core_pkg.sv
// Shared fetch-path constants and types.
//   RESET_VECTOR_DEFAULT : default first fetch address after reset
//   INSTR_WIDTH          : instruction word width
//   PC_INCREMENT         : byte step between sequential fetches
//   fetch_entry_t        : one buffered instruction {pc, data}
package cpu_core_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_WIDTH          = 32;
  localparam logic [31:0] PC_INCREMENT         = 32'd4;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Parameterised FIFO holding fetched instructions.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_entry at the tail (caller guarantees !full or pop)
//   pop         : drop the head (caller guarantees !empty)
//   flush       : empty the buffer; overrides push and pop
//   head_entry  : current head (undefined when empty)
//   count       : number of valid entries
//   full, empty : occupancy flags
module fetch_buffer
  import cpu_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head_entry,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, redirect handling and a
// small decoupling buffer between instruction memory and decode.
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   IMEM_ADDRESS          : fetch address (word aligned, equals fetch PC)
//   IMEM_READ_DATA        : instruction word for IMEM_ADDRESS
//   IMEM_BUSYWAIT         : memory not ready, read data invalid
//   REDIRECT_VALID/TARGET : taken branch/jump; flush and refetch from target
//   INSTR_VALID/READY     : handshake with decode
//   INSTR_DATA/INSTR_PC   : head instruction and its address (zero when invalid)
module instruction_fetch_unit
  import cpu_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned BUF_DEPTH    = 2
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  output logic [31:0]            IMEM_ADDRESS,
  input  logic [INSTR_WIDTH-1:0] IMEM_READ_DATA,
  input  logic                   IMEM_BUSYWAIT,
  input  logic                   REDIRECT_VALID,
  input  logic [31:0]            REDIRECT_TARGET,
  output logic                   INSTR_VALID,
  input  logic                   INSTR_READY,
  output logic [INSTR_WIDTH-1:0] INSTR_DATA,
  output logic [31:0]            INSTR_PC
);

  localparam logic [31:0] ResetPc = {RESET_VECTOR[31:2], 2'b00};

  logic [31:0]                       pc_q, pc_d;
  logic                              push, pop;
  logic                              buf_full, buf_empty;
  logic [$clog2(BUF_DEPTH+1)-1:0]    buf_count;
  fetch_entry_t                      push_entry, head_entry;

  // Redirect wins: it flushes the buffer, so neither push nor pop takes effect.
  assign pop  = !buf_empty && INSTR_READY && !REDIRECT_VALID;
  assign push = !IMEM_BUSYWAIT && !REDIRECT_VALID && (!buf_full || pop);

  assign push_entry = '{pc: pc_q, data: IMEM_READ_DATA};

  always_comb begin
    pc_d = pc_q;
    if (REDIRECT_VALID) begin
      pc_d = {REDIRECT_TARGET[31:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + PC_INCREMENT;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) pc_q <= ResetPc;
    else          pc_q <= pc_d;
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (REDIRECT_VALID),
    .head_entry (head_entry),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  assign IMEM_ADDRESS = pc_q;
  assign INSTR_VALID  = !buf_empty;
  assign INSTR_DATA   = buf_empty ? '0 : head_entry.data;
  assign INSTR_PC     = buf_empty ? '0 : head_entry.pc;

  // Occupancy is fully summarised by full/empty at this level.
  logic unused_count;
  assign unused_count = ^buf_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IMEM_READ_DATA;
  logic        IMEM_BUSYWAIT;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_TARGET;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] INSTR_DATA;
  logic [31:0] INSTR_PC;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  // Memory model: word is a fixed scramble of its address; garbage while busy.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
  endfunction

  assign IMEM_READ_DATA = IMEM_BUSYWAIT ? 32'hDEAD_DEAD : mem_word(IMEM_ADDRESS);

  instruction_fetch_unit dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .IMEM_ADDRESS    (IMEM_ADDRESS),
    .IMEM_READ_DATA  (IMEM_READ_DATA),
    .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
    .REDIRECT_VALID  (REDIRECT_VALID),
    .REDIRECT_TARGET (REDIRECT_TARGET),
    .INSTR_VALID     (INSTR_VALID),
    .INSTR_READY     (INSTR_READY),
    .INSTR_DATA      (INSTR_DATA),
    .INSTR_PC        (INSTR_PC)
  );

  typedef struct {
    logic        bw;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] eaddr);
    check({tag, " valid"}, {31'b0, INSTR_VALID}, {31'b0, ev});
    check({tag, " pc"},    INSTR_PC,   ev ? epc : 32'h0);
    check({tag, " data"},  INSTR_DATA, ev ? mem_word(epc) : 32'h0);
    check({tag, " addr"},  IMEM_ADDRESS, eaddr);
  endtask

  initial begin
    //           bw    rdy   redir tgt            valid pc             addr
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 32'h0000_0008};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0008};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0008};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0008};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 32'h0000_000C};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_0010};
    // decode stalls: buffer fills to 2, PC stops at 0xC + 8
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_0014};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_0014};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_0014};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_0014};
    // push+pop while full, then drain
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 32'h0000_0018};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 32'h0000_0018};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0018};
    // redirect during busywait, misaligned target
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h0000_001B, 1'b0, 32'h0,         32'h0000_0018};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0018, 32'h0000_001C};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0018, 32'h0000_0020};
    // redirect to 0x103 while full
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         32'h0000_0100};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 32'h0000_0104};
    // redirect with decode ready and head valid, toward the top of memory
    vecs[19] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         32'hFFFF_FFF8};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_0004};

    RESET_N         = 1'b0;
    IMEM_BUSYWAIT   = 1'b0;
    REDIRECT_VALID  = 1'b0;
    REDIRECT_TARGET = 32'h0;
    INSTR_READY     = 1'b1;

    #2;
    check_all("reset", 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    check_all("reset_edge", 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 23; i++) begin
      IMEM_BUSYWAIT   = vecs[i].bw;
      INSTR_READY     = vecs[i].rdy;
      REDIRECT_VALID  = vecs[i].redir;
      REDIRECT_TARGET = vecs[i].tgt;
      @(posedge CLK); #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_addr);
    end

    // Two entries buffered now; asynchronous reset mid-stream.
    REDIRECT_VALID = 1'b0;
    IMEM_BUSYWAIT  = 1'b0;
    INSTR_READY    = 1'b1;
    RESET_N        = 1'b0;
    #1;
    check_all("midreset", 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    check_all("midreset_edge", 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    check_all("restart0", 1'b1, 32'h0, 32'h4);
    @(posedge CLK); #1;
    check_all("restart1", 1'b1, 32'h4, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000: first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries, power of two, 2..8.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IMEM_ADDRESS  output  32  fetch address to instruction memory, bits [1:0] always 2'b00.
REQ-006 SHALL have port IMEM_READ_DATA  input  32  instruction word for IMEM_ADDRESS.
REQ-007 SHALL have port IMEM_BUSYWAIT  input  1  memory not ready; IMEM_READ_DATA invalid while high.
REQ-008 SHALL have port REDIRECT_VALID  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port REDIRECT_TARGET  input  32  new fetch address.
REQ-010 SHALL have port INSTR_VALID  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port INSTR_READY  input  1  decode accepts head this cycle.
REQ-012 SHALL have port INSTR_DATA  output  32  head instruction word.
REQ-013 SHALL have port INSTR_PC  output  32  address of head instruction.

Function
REQ-014 SHALL hold a fetch PC register; IMEM_ADDRESS SHALL equal it combinationally.
REQ-015 SHALL push {fetch PC, IMEM_READ_DATA} at an edge when IMEM_BUSYWAIT=0, REDIRECT_VALID=0, and (count<BUF_DEPTH or a pop occurs that edge).
REQ-016 SHALL advance fetch PC by 4 on each push, modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
REQ-017 SHALL hold fetch PC unchanged while IMEM_BUSYWAIT=1 or buffer full without pop.
REQ-018 SHALL pop the head on an edge where INSTR_VALID=1 and INSTR_READY=1.
REQ-019 SHALL drive INSTR_VALID=(count!=0), INSTR_DATA/INSTR_PC from head; head SHALL stay stable while INSTR_VALID=1 and INSTR_READY=0.
REQ-020 SHALL support simultaneous push and pop, count unchanged, including when full.
REQ-021 Buffer read/write pointers SHALL wrap modulo BUF_DEPTH.
REQ-022 SHALL treat REDIRECT_VALID=1 with top priority: at that edge, count<=0, no push, no pop counted, fetch PC<={REDIRECT_TARGET[31:2],2'b00}.
REQ-023 Latency: instruction available at IMEM with BUSYWAIT=0 at edge N SHALL appear with INSTR_VALID=1 after edge N (one cycle); after redirect at edge N, first new instruction valid no earlier than after edge N+1.
REQ-024 Sustained throughput SHALL be one instruction per cycle when BUSYWAIT=0 and INSTR_READY=1.
REQ-025 INSTR_DATA/INSTR_PC SHALL be 32'h0 when INSTR_VALID=0.

Reset
REQ-026 RESET_N low SHALL immediately set fetch PC=RESET_VECTOR, count=0, pointers=0, INSTR_VALID=0, INSTR_DATA=0, INSTR_PC=0.
REQ-027 Reset mid-operation SHALL discard buffered instructions and any pending fetch; no push at the edge where RESET_N is low.
REQ-028 First push SHALL occur at the first rising edge after RESET_N deasserts with IMEM_BUSYWAIT=0.

Structure
REQ-029 RESET_VECTOR default, instruction width 32, and PC increment 4 SHALL live in shared package cpu_core_pkg.
REQ-030 Buffer SHALL be sub-module fetch_buffer (parameterised FIFO, push/pop/flush, count); PC logic in top.

Verification
REQ-031 Reset, BUSYWAIT=0, READY=1, memory words at 0x0/0x4/0x8 -> INSTR_PC 0x0,0x4,0x8 on consecutive cycles, data matches.
REQ-032 BUSYWAIT held high 3 cycles at PC 0x8 -> IMEM_ADDRESS stays 0x8, no push; word at 0x8 delivered exactly once after release.
REQ-033 READY=0 for 4 cycles -> count reaches 2, PC stops at base+8, head stable; READY=1 -> entries drain in order, no loss/duplication.
REQ-034 REDIRECT_VALID with target 0x103 while buffer full -> INSTR_VALID=0 next cycle, IMEM_ADDRESS=0x100, next INSTR_PC=0x100.
REQ-035 Fetch PC 0xFFFFFFFC -> next IMEM_ADDRESS=0x00000000; RESET_N pulsed low mid-stream with 2 entries -> INSTR_VALID=0 immediately, restart at RESET_VECTOR.
